// File: rtl/factorial_core.sv
// factorial_core: bus-mapped N! engine, 64-bit operand, 128-bit result.
// One 128x64 multiply step per cycle, done/busy status, level interrupt.
module factorial_core (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_sel,
  input  logic        s_wr,
  input  logic [15:0] s_addr,
  input  logic [63:0] s_din,
  output logic [63:0] s_dout,
  output logic        interrupt
);

  localparam logic [12:0] A_START = 13'hE00;
  localparam logic [12:0] A_CLEAR = 13'hE01;
  localparam logic [12:0] A_DONE  = 13'hE02;
  localparam logic [12:0] A_INTR  = 13'hE03;
  localparam logic [12:0] A_OPND  = 13'hE04;
  localparam logic [12:0] A_RESH  = 13'hE05;
  localparam logic [12:0] A_RESL  = 13'hE06;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [127:0]  result_q, result_d;
  logic [63:0]   counter_q, counter_d;
  logic [63:0]   operand_q, operand_d;
  logic          intren_q, intren_d;

  logic [12:0]   idx;
  logic          wr, rd;
  logic          done, busy;
  logic [127:0]  prod;
  logic [63:0]   cnt_dec;
  logic          unused_addr;

  assign idx         = s_addr[15:3];
  assign unused_addr = ^s_addr[2:0];
  assign wr          = s_sel & s_wr;
  assign rd          = s_sel & ~s_wr;
  assign done        = (state_q == DONE);
  assign busy        = (state_q == INIT) | (state_q == MUL);
  assign prod        = result_q * {64'd0, counter_q};
  assign cnt_dec     = counter_q - 64'd1;
  assign interrupt   = intren_q & done;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    counter_d = counter_q;
    operand_d = operand_q;
    intren_d  = intren_q;

    if (wr && idx == A_INTR)
      intren_d = s_din[0];
    if (wr && idx == A_OPND && state_q == IDLE)
      operand_d = s_din;

    unique case (state_q)
      IDLE: begin
        if (wr && idx == A_START && s_din[0])
          state_d = INIT;
      end
      INIT: begin
        result_d  = 128'd1;
        counter_d = operand_q;
        state_d   = (operand_q <= 64'd1) ? DONE : MUL;
      end
      MUL: begin
        result_d  = prod;
        counter_d = cnt_dec;
        if (cnt_dec == 64'd1)
          state_d = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // abort wins over any in-flight step
    if (wr && idx == A_CLEAR && s_din[0]) begin
      state_d   = IDLE;
      result_d  = '0;
      counter_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      counter_q <= '0;
      operand_q <= '0;
      intren_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      counter_q <= counter_d;
      operand_q <= operand_d;
      intren_q  <= intren_d;
    end
  end

  always_comb begin
    s_dout = '0;
    if (rd) begin
      unique case (1'b1)
        (idx == A_DONE): s_dout = {62'd0, busy, done};
        (idx == A_INTR): s_dout = {63'd0, intren_q};
        (idx == A_OPND): s_dout = operand_q;
        (idx == A_RESH): s_dout = result_q[127:64];
        (idx == A_RESL): s_dout = result_q[63:0];
        default:         s_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_factorial_core.sv
// Directed bench for factorial_core with hand-computed factorials.
// Bus tasks leave the bus idle between transfers.
module tb_factorial_core;

  logic        clk;
  logic        reset_n;
  logic        s_sel;
  logic        s_wr;
  logic [15:0] s_addr;
  logic [63:0] s_din;
  logic [63:0] s_dout;
  logic        interrupt;

  int checks;
  int failures;

  factorial_core dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_sel     (s_sel),
    .s_wr      (s_wr),
    .s_addr    (s_addr),
    .s_din     (s_din),
    .s_dout    (s_dout),
    .interrupt (interrupt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    s_sel  = 1'b1;
    s_wr   = 1'b1;
    s_addr = a;
    s_din  = d;
    @(posedge clk);
    #1;
    s_sel  = 1'b0;
    s_wr   = 1'b0;
    s_din  = '0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [15:0] a, output logic [63:0] d);
    s_sel  = 1'b1;
    s_wr   = 1'b0;
    s_addr = a;
    #1;
    d      = s_dout;
    s_sel  = 1'b0;
    #1;
  endtask

  task automatic poll(input string tag, input int lim, input logic ien,
                      output int edges, output logic irq_any);
    logic [63:0] v;
    logic        got;
    logic        irq_bad;
    got     = 1'b0;
    irq_any = 1'b0;
    irq_bad = 1'b0;
    edges   = 0;
    for (int k = 0; k <= lim + 4; k++) begin
      rd(16'h7010, v);
      irq_any = irq_any | interrupt;
      if (interrupt !== (v[0] & ien))
        irq_bad = 1'b1;
      if (v[0] === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      edges++;
    end
    chk({tag, "_done"}, 128'(got), 128'd1);
    chk({tag, "_latency_ok"}, 128'(edges <= lim), 128'd1);
    chk({tag, "_irq_tracks_done"}, 128'(irq_bad), 128'd0);
  endtask

  logic [63:0] v, h;
  int          e;
  logic        ia;

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    s_sel    = 1'b0;
    s_wr     = 1'b0;
    s_addr   = '0;
    s_din    = '0;

    // reset state
    @(negedge clk);
    chk("rst_dout", 128'(s_dout), 128'd0);
    chk("rst_irq", 128'(interrupt), 128'd0);
    rd(16'h7020, v);
    chk("rst_operand", 128'(v), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(16'h7010, v);
    chk("post_rst_opdone", 128'(v), 128'd0);
    rd(16'h7038, v);
    chk("unmapped_read", 128'(v), 128'd0);

    // start with bit0=0 is ignored
    wr(16'h7000, 64'h2);
    @(negedge clk);
    rd(16'h7010, v);
    chk("start_bit0_zero", 128'(v), 128'd0);

    // 19!, interrupt disabled
    wr(16'h7021, 64'd19);
    wr(16'h7018, 64'd0);
    rd(16'h7020, v);
    chk("operand_rb", 128'(v), 128'd19);
    wr(16'h7000, 64'd1);
    poll("f19", 21, 1'b0, e, ia);
    chk("f19_irq_low", 128'(ia), 128'd0);
    rd(16'h7028, h);
    rd(16'h7030, v);
    chk("f19_res", {h, v}, 128'h01B02B9306890000);
    wr(16'h7018, 64'd1);
    chk("irq_enable_in_done", 128'(interrupt), 128'd1);
    wr(16'h7018, 64'd0);
    chk("irq_disable_in_done", 128'(interrupt), 128'd0);
    wr(16'h7008, 64'd1);

    // 20! with interrupt, then clear
    wr(16'h7018, 64'd1);
    wr(16'h7020, 64'd20);
    wr(16'h7000, 64'd1);
    poll("f20", 22, 1'b1, e, ia);
    chk("f20_irq", 128'(interrupt), 128'd1);
    rd(16'h7028, h);
    rd(16'h7030, v);
    chk("f20_res", {h, v}, 128'h21C3677C82B40000);
    wr(16'h7008, 64'd1);
    chk("f20_clr_irq", 128'(interrupt), 128'd0);
    rd(16'h7010, v);
    chk("f20_clr_opdone", 128'(v), 128'd0);
    rd(16'h7030, v);
    chk("f20_clr_resl", 128'(v), 128'd0);

    // 0! and 1! through aliased addresses
    wr(16'h7027, 64'd0);
    wr(16'h7019, 64'd1);
    wr(16'h7006, 64'd1);
    poll("f0", 2, 1'b1, e, ia);
    rd(16'h7030, v);
    chk("f0_res", 128'(v), 128'd1);
    chk("f0_irq", 128'(interrupt), 128'd1);
    wr(16'h700F, 64'd1);
    wr(16'h7025, 64'd1);
    wr(16'h7005, 64'd1);
    poll("f1", 2, 1'b1, e, ia);
    rd(16'h7031, v);
    chk("f1_res", 128'(v), 128'd1);
    wr(16'h7008, 64'd1);

    // 34!, largest exact result
    wr(16'h7020, 64'd34);
    wr(16'h7000, 64'd1);
    poll("f34", 36, 1'b1, e, ia);
    rd(16'h7028, h);
    rd(16'h7030, v);
    chk("f34_res", {h, v}, 128'hDE1BC4D19EFCAC82445DA75B00000000);
    wr(16'h7008, 64'd1);

    // abort mid-run on 30
    wr(16'h7020, 64'd30);
    wr(16'h7000, 64'd1);
    repeat (4) @(negedge clk);
    rd(16'h7010, v);
    chk("f30_busy", 128'(v), 128'd2);
    wr(16'h7008, 64'd1);
    rd(16'h7010, v);
    chk("abort_opdone", 128'(v), 128'd0);
    rd(16'h7028, h);
    rd(16'h7030, v);
    chk("abort_result", {h, v}, 128'd0);
    rd(16'h7020, v);
    chk("abort_operand_kept", 128'(v), 128'd30);
    rd(16'h7018, v);
    chk("abort_intren_kept", 128'(v), 128'd1);
    repeat (3) @(negedge clk);
    rd(16'h7010, v);
    chk("abort_stays_idle", 128'(v), 128'd0);

    // writes ignored while busy
    wr(16'h7020, 64'd10);
    wr(16'h7000, 64'd1);
    rd(16'h7010, v);
    chk("f10_busy", 128'(v), 128'd2);
    wr(16'h7020, 64'd5);
    wr(16'h7000, 64'd1);
    rd(16'h7020, v);
    chk("busy_operand_kept", 128'(v), 128'd10);
    poll("f10", 12, 1'b1, e, ia);
    rd(16'h7028, h);
    rd(16'h7030, v);
    chk("f10_res", {h, v}, 128'h375F00);
    wr(16'h7020, 64'd7);
    rd(16'h7020, v);
    chk("done_operand_kept", 128'(v), 128'd10);
    wr(16'h7008, 64'd1);

    // async reset mid-run
    wr(16'h7020, 64'd34);
    wr(16'h7000, 64'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    rd(16'h7020, v);
    chk("midrst_operand", 128'(v), 128'd0);
    rd(16'h7010, v);
    chk("midrst_opdone", 128'(v), 128'd0);
    chk("midrst_irq", 128'(interrupt), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    rd(16'h7010, v);
    chk("postrst_idle", 128'(v), 128'd0);
    rd(16'h7018, v);
    chk("postrst_intren", 128'(v), 128'd0);
    s_addr = 16'h7020;
    s_wr   = 1'b1;
    #1;
    chk("dout_on_write", 128'(s_dout), 128'd0);
    s_wr   = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
